// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types for the pipeline stall/flush scheduler.
//   pipe_ctrl_state_e  - scheduler state (RUN, PEND, RECOVER)
//   redirect_kind_e    - what caused a redirect (branch mispredict or exception/eret)
//   pending_redirect_t - a held redirect {valid, kind, target}
//   merge_redirect()   - priority merge of a held redirect with this cycle's events
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    RECOVER
  } pipe_ctrl_state_e;

  typedef enum logic {
    RK_BP,
    RK_EXC
  } redirect_kind_e;

  typedef struct packed {
    logic           valid;
    redirect_kind_e kind;
    logic [31:0]    target;
  } pending_redirect_t;

  // Exceptions always win; a new mispredict only lands in an empty slot,
  // so the older branch is kept and a held exception is never displaced.
  function automatic pending_redirect_t merge_redirect(
    input pending_redirect_t held,
    input logic              exc,
    input logic [31:0]       exc_target,
    input logic              bp,
    input logic [31:0]       bp_target
  );
    pending_redirect_t r;
    r = held;
    if (exc) begin
      r.valid  = 1'b1;
      r.kind   = RK_EXC;
      r.target = exc_target;
    end else if (bp && !held.valid) begin
      r.valid  = 1'b1;
      r.kind   = RK_BP;
      r.target = bp_target;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_ctrl_pending.sv
// pipe_ctrl_pending: holds the redirect deferred while exec is stalled and
// presents the merge of that held redirect with the current cycle's events.
// Ports:
//   clk, resetn            clock, async active-low reset
//   clear                  drop the held redirect (it is being applied)
//   capture                store the merged redirect
//   exc, exc_target        exception/eret event and its target
//   bp, bp_target          (already qualified) mispredict event and its target
//   merged_kind/target     kind/target of held-merged-with-current redirect
module pipe_ctrl_pending
  import pipe_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           clear,
  input  logic           capture,
  input  logic           exc,
  input  logic [31:0]    exc_target,
  input  logic           bp,
  input  logic [31:0]    bp_target,
  output redirect_kind_e merged_kind,
  output logic [31:0]    merged_target
);

  pending_redirect_t held;
  pending_redirect_t merged;

  always_comb begin
    merged        = merge_redirect(held, exc, exc_target, bp, bp_target);
    merged_kind   = merged.kind;
    merged_target = merged.target;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held <= '0;
    end else if (clear) begin
      held <= '0;
    end else if (capture) begin
      held <= merged;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush scheduler for the dual-issue core.
// Ports:
//   clk, resetn                     clock, async active-low reset
//   mem_halt, div_halt              exec stall sources
//   fetch_halt                      issue queue full
//   bp_fail, bp_target              BRU mispredict and not-taken PC
//   cp0_flush, eret, exc_target     commit-time exception/eret and its target
//   fetch_en, issue_en, exec_en     stage advance enables
//   commit_valid                    0 writes a bubble into exec_result
//   flush_front/exec_in/exec_pipe   stage clear strobes
//   redirect_valid, redirect_pc     registered one-cycle redirect to fetch1
//   stall_cycles                    count of exec-stalled cycles (wraps)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RECOVER_CYCLES = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mem_halt,
  input  logic             div_halt,
  input  logic             fetch_halt,
  input  logic             bp_fail,
  input  logic [31:0]      bp_target,
  input  logic             cp0_flush,
  input  logic             eret,
  input  logic [31:0]      exc_target,
  output logic             fetch_en,
  output logic             issue_en,
  output logic             exec_en,
  output logic             commit_valid,
  output logic             flush_front,
  output logic             flush_exec_in,
  output logic             flush_exec_pipe,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned RC_W = (RECOVER_CYCLES > 0) ? $clog2(RECOVER_CYCLES + 1) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RECOVER_CYCLES);

  pipe_ctrl_state_e state, state_next;
  logic [RC_W-1:0]  rc_cnt;
  logic             stall, exc, bp_eff, evt;
  logic             apply, capture;
  redirect_kind_e   merged_kind;
  logic [31:0]      merged_target;

  assign stall  = mem_halt | div_halt;
  assign exc    = cp0_flush | eret;
  // Mispredicts are from the squashed path while recovering, so drop them.
  assign bp_eff = bp_fail & (state != RECOVER);
  assign evt    = exc | bp_eff;

  pipe_ctrl_pending u_pending (
    .clk           (clk),
    .resetn        (resetn),
    .clear         (apply),
    .capture       (capture),
    .exc           (exc),
    .exc_target    (exc_target),
    .bp            (bp_eff),
    .bp_target     (bp_target),
    .merged_kind   (merged_kind),
    .merged_target (merged_target)
  );

  always_comb begin
    state_next      = state;
    fetch_en        = ~fetch_halt;
    issue_en        = 1'b1;
    exec_en         = 1'b1;
    commit_valid    = 1'b1;
    flush_front     = 1'b0;
    flush_exec_in   = 1'b0;
    flush_exec_pipe = 1'b0;
    apply           = 1'b0;
    capture         = 1'b0;

    case (state)
      RUN, RECOVER: begin
        if (state == RECOVER) begin
          issue_en     = 1'b0;
          fetch_en     = 1'b1;
          exec_en      = ~stall;
          commit_valid = ~stall;
          if (rc_cnt == RC_W'(1)) begin
            state_next = RUN;
          end
        end else if (stall) begin
          issue_en     = 1'b0;
          exec_en      = 1'b0;
          commit_valid = 1'b0;
        end
        if (evt) begin
          if (stall) begin
            // Front end can be dropped now; exec must drain before redirecting.
            fetch_en     = ~fetch_halt;
            issue_en     = 1'b0;
            exec_en      = 1'b0;
            commit_valid = 1'b0;
            flush_front  = 1'b1;
            capture      = 1'b1;
            state_next   = PEND;
          end else begin
            apply = 1'b1;
          end
        end
      end
      PEND: begin
        if (stall) begin
          issue_en     = 1'b0;
          exec_en      = 1'b0;
          commit_valid = 1'b0;
          capture      = 1'b1;
        end else begin
          apply = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase

    if (apply) begin
      fetch_en        = ~fetch_halt;
      issue_en        = 1'b1;
      exec_en         = 1'b1;
      commit_valid    = 1'b0;
      flush_front     = 1'b1;
      flush_exec_in   = 1'b1;
      flush_exec_pipe = (merged_kind == RK_EXC);
      state_next      = (RECOVER_CYCLES > 0) ? RECOVER : RUN;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= RUN;
      rc_cnt         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall_cycles   <= '0;
    end else begin
      state          <= state_next;
      redirect_valid <= apply;
      stall_cycles   <= stall_cycles + CNT_W'(stall);
      if (apply) begin
        redirect_pc <= merged_target;
        rc_cnt      <= RC_LOAD;
      end else if (state == RECOVER && rc_cnt != '0) begin
        rc_cnt <= rc_cnt - RC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_halt, div_halt, fetch_halt, bp_fail, cp0_flush, eret;
  logic [31:0] bp_target, exc_target;

  logic        a_fe, a_ie, a_ee, a_cv, a_ff, a_fi, a_fp, a_rv;
  logic [31:0] a_rpc, a_sc;
  logic        b_fe, b_ie, b_ee, b_cv, b_ff, b_fi, b_fp, b_rv;
  logic [31:0] b_rpc;
  logic [3:0]  b_sc;

  always #5 clk = ~clk;

  pipe_ctrl #(.RECOVER_CYCLES(1), .CNT_W(32)) dut0 (
    .clk(clk), .resetn(resetn), .mem_halt(mem_halt), .div_halt(div_halt),
    .fetch_halt(fetch_halt), .bp_fail(bp_fail), .bp_target(bp_target),
    .cp0_flush(cp0_flush), .eret(eret), .exc_target(exc_target),
    .fetch_en(a_fe), .issue_en(a_ie), .exec_en(a_ee), .commit_valid(a_cv),
    .flush_front(a_ff), .flush_exec_in(a_fi), .flush_exec_pipe(a_fp),
    .redirect_valid(a_rv), .redirect_pc(a_rpc), .stall_cycles(a_sc)
  );

  pipe_ctrl #(.RECOVER_CYCLES(3), .CNT_W(4)) dut1 (
    .clk(clk), .resetn(resetn), .mem_halt(mem_halt), .div_halt(div_halt),
    .fetch_halt(fetch_halt), .bp_fail(bp_fail), .bp_target(bp_target),
    .cp0_flush(cp0_flush), .eret(eret), .exc_target(exc_target),
    .fetch_en(b_fe), .issue_en(b_ie), .exec_en(b_ee), .commit_valid(b_cv),
    .flush_front(b_ff), .flush_exec_in(b_fi), .flush_exec_pipe(b_fp),
    .redirect_valid(b_rv), .redirect_pc(b_rpc), .stall_cycles(b_sc)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, one slot per DUT instance.
  // mode: 0 normal, 1 holding a deferred redirect, 2 issue hold after redirect.
  int unsigned      rcs[2]  = '{1, 3};
  longint unsigned  modv[2] = '{64'h1_0000_0000, 64'd16};
  int               mode[2];
  int               hold[2];
  bit               pv[2], pk[2];
  logic [31:0]      pt[2];
  bit               m_rv[2];
  logic [31:0]      m_rpc[2];
  longint unsigned  m_sc[2];

  typedef struct packed { bit fe, ie, ee, cv, ff, fi, fp; } comb_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; hold[i] = 0; pv[i] = 0; pk[i] = 0; pt[i] = '0;
      m_rv[i] = 0; m_rpc[i] = '0; m_sc[i] = 0;
    end
  endtask

  // Expected combinational outputs for this cycle, then advance the model past the clock edge.
  task automatic model_tick(input int i, output comb_t e);
    bit stall, exc, bpv, cv_, ck, do_apply;
    logic [31:0] ct;
    stall = mem_halt | div_halt;
    exc   = cp0_flush | eret;
    bpv   = bp_fail && (mode[i] != 2);
    cv_ = 0; ck = 0; ct = '0;
    if (exc) begin
      cv_ = 1; ck = 1; ct = exc_target;
    end else if (mode[i] == 1 && pv[i]) begin
      cv_ = 1; ck = pk[i]; ct = pt[i];
    end else if (bpv) begin
      cv_ = 1; ck = 0; ct = bp_target;
    end
    e = '{fe: !fetch_halt, ie: 1, ee: 1, cv: 1, ff: 0, fi: 0, fp: 0};
    do_apply = 0;
    if (mode[i] == 1 || cv_) begin
      if (stall) begin
        if (mode[i] != 1) e.ff = 1;
        e.ie = 0; e.ee = 0; e.cv = 0;
        pv[i] = cv_; pk[i] = ck; pt[i] = ct; mode[i] = 1;
      end else begin
        do_apply = 1;
      end
    end else if (mode[i] == 2) begin
      e.ie = 0; e.fe = 1; e.ee = !stall; e.cv = !stall;
      hold[i]--;
      if (hold[i] == 0) mode[i] = 0;
    end else if (stall) begin
      e.ie = 0; e.ee = 0; e.cv = 0;
    end
    m_rv[i] = do_apply;
    if (do_apply) begin
      e.ff = 1; e.fi = 1; e.fp = ck; e.cv = 0;
      m_rpc[i] = ct; pv[i] = 0;
      if (rcs[i] > 0) begin mode[i] = 2; hold[i] = int'(rcs[i]); end
      else mode[i] = 0;
    end
    m_sc[i] = (m_sc[i] + 64'(stall)) % modv[i];
  endtask

  task automatic check_regs();
    chk("d0.redirect_valid", 64'(a_rv), 64'(m_rv[0]));
    chk("d0.redirect_pc", 64'(a_rpc), 64'(m_rpc[0]));
    chk("d0.stall_cycles", 64'(a_sc), m_sc[0]);
    chk("d1.redirect_valid", 64'(b_rv), 64'(m_rv[1]));
    chk("d1.redirect_pc", 64'(b_rpc), 64'(m_rpc[1]));
    chk("d1.stall_cycles", 64'(b_sc), m_sc[1]);
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    comb_t e0, e1;
    @(negedge clk);
    check_regs();
    model_tick(0, e0);
    model_tick(1, e1);
    chk("d0.comb", 64'({a_fe, a_ie, a_ee, a_cv, a_ff, a_fi, a_fp}), 64'(e0));
    chk("d1.comb", 64'({b_fe, b_ie, b_ee, b_cv, b_ff, b_fi, b_fp}), 64'(e1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_halt = 0; div_halt = 0; fetch_halt = 0; bp_fail = 0; cp0_flush = 0; eret = 0;
    bp_target = '0; exc_target = '0;
  endtask

  // Asynchronous reset asserted mid-cycle; registers must clear without a clock edge.
  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    #1;
    model_reset();
    check_regs();
    chk("d0.comb_reset", 64'({a_fe, a_ie, a_ee, a_cv, a_ff, a_fi, a_fp}), 64'h78);
    chk("d1.comb_reset", 64'({b_fe, b_ie, b_ee, b_cv, b_ff, b_fi, b_fp}), 64'h78);
    @(posedge clk);
    #1;
    resetn = 1;
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    resetn = 1;
    cycle();

    // Mispredict with no stall.
    bp_fail = 1; bp_target = 32'hBFC0_0100;
    cycle();
    idle_inputs();
    chk("bp.redirect_valid", 64'(a_rv), 64'd1);
    chk("bp.redirect_pc", 64'(a_rpc), 64'hBFC0_0100);
    repeat (5) cycle();

    // Exception arriving mid-stall is deferred until the stall drops.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      mem_halt = 1;
      cp0_flush = (c == 2); exc_target = 32'hBFC0_0380;
      cycle();
    end
    idle_inputs();
    cycle();
    chk("stall5.redirect_valid", 64'(a_rv), 64'd1);
    chk("stall5.redirect_pc", 64'(a_rpc), 64'hBFC0_0380);
    chk("stall5.stall_cycles", 64'(a_sc), 64'd5);
    repeat (4) cycle();

    // Pending mispredict overwritten by eret.
    mem_halt = 1; bp_fail = 1; bp_target = 32'h100;
    cycle();
    bp_fail = 0; eret = 1; exc_target = 32'h200;
    cycle();
    idle_inputs();
    cycle();
    chk("pend_eret.redirect_pc", 64'(a_rpc), 64'h200);
    repeat (4) cycle();

    // Exception and mispredict in the same cycle.
    cp0_flush = 1; exc_target = 32'h380; bp_fail = 1; bp_target = 32'h100;
    cycle();
    idle_inputs();
    chk("same.redirect_pc", 64'(a_rpc), 64'h380);
    repeat (4) cycle();

    // Reset while holding a deferred redirect, then while in issue hold.
    mem_halt = 1; bp_fail = 1; bp_target = 32'h444;
    cycle();
    do_reset();
    repeat (3) cycle();
    chk("rst_pend.no_redirect", 64'(a_rv), 64'd0);
    bp_fail = 1; bp_target = 32'h555;
    cycle();
    idle_inputs();
    do_reset();
    repeat (3) cycle();
    chk("rst_rec.no_redirect", 64'(b_rv), 64'd0);

    // Issue hold of 3 cycles and counter wrap on the narrow instance.
    bp_fail = 1; bp_target = 32'h600;
    cycle();
    idle_inputs();
    repeat (5) cycle();
    do_reset();
    mem_halt = 1;
    repeat (15) cycle();
    chk("wrap.at_max", 64'(b_sc), 64'd15);
    cycle();
    chk("wrap.to_zero", 64'(b_sc), 64'd0);
    idle_inputs();
    cycle();

    // Random traffic with occasional resets.
    for (int n = 0; n < 2500; n++) begin
      mem_halt   = ($urandom_range(0, 99) < 30);
      div_halt   = ($urandom_range(0, 99) < 12);
      fetch_halt = ($urandom_range(0, 99) < 20);
      bp_fail    = ($urandom_range(0, 99) < 15);
      cp0_flush  = ($urandom_range(0, 99) < 5);
      eret       = ($urandom_range(0, 99) < 4);
      bp_target  = $urandom;
      exc_target = $urandom;
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end
    idle_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
